// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multicycle controller.
// Holds the state enum, opcode/funct constants, ALU and mux encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_ADDIEX,
    S_ADDIWB,
    S_JUMP,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_ONE   = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_OUT = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  function automatic state_t decode_next(input logic [5:0] op);
    state_t s;
    unique case (op)
      OP_LW, OP_SW: s = S_MEMADR;
      OP_RTYPE:     s = S_EXEC;
      OP_BEQ:       s = S_BRANCH;
      OP_ADDI:      s = S_ADDIEX;
      OP_J:         s = S_JUMP;
      default:      s = S_TRAP;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/alu_dec.sv
// alu_dec: R-type funct to ALU control decode.
// Ports: funct (in), alucontrol (out), valid (out, funct is supported).
module alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  always_comb begin
    alucontrol = ALU_ADD;
    valid      = 1'b1;
    unique case (funct)
      FN_ADD:  alucontrol = ALU_ADD;
      FN_SUB:  alucontrol = ALU_SUB;
      FN_AND:  alucontrol = ALU_AND;
      FN_OR:   alucontrol = ALU_OR;
      FN_SLT:  alucontrol = ALU_SLT;
      default: begin
        alucontrol = ALU_AND;
        valid      = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset controller FSM (lw/sw/R/beq/addi/j).
// In: clk, rst (async low), op, funct, zero, mem_rdy. Out: enables, selects, retire, illegal.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_rdy,
  output logic       pcen,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       retire,
  output logic       illegal
);

  state_t     state_q, state_d;
  logic [2:0] fn_alu;
  logic       fn_ok;

  alu_dec u_alu_dec (
    .funct      (funct),
    .alucontrol (fn_alu),
    .valid      (fn_ok)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_rdy) state_d = S_DECODE;
      S_DECODE: state_d = decode_next(op);
      S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
      S_EXEC:   state_d = fn_ok ? S_ALUWB : S_TRAP;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_ADDIWB,
      S_BRANCH, S_JUMP:
                state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    pcen       = 1'b0;
    irwrite    = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_B;
    pcsrc      = PC_ALU;
    alucontrol = 3'b000;
    retire     = 1'b0;
    illegal    = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        alusrcb    = SRCB_ONE;
        alucontrol = ALU_ADD;
        irwrite    = mem_rdy;
        pcen       = mem_rdy;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMMSH;
        alucontrol = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = mem_rdy;
        retire   = mem_rdy;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        retire   = 1'b1;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alucontrol = fn_alu;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        retire   = 1'b1;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PC_OUT;
        pcen       = zero;
        retire     = 1'b1;
      end
      S_JUMP: begin
        pcsrc  = PC_JMP;
        pcen   = 1'b1;
        retire = 1'b1;
      end
      S_TRAP: illegal = 1'b1;
      default: illegal = 1'b1;
    endcase
    // Reset masks FETCH's mem_rdy-driven enables and selects at once.
    if (!rst) begin
      pcen       = 1'b0;
      irwrite    = 1'b0;
      regwrite   = 1'b0;
      memwrite   = 1'b0;
      iord       = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      alucontrol = 3'b000;
      retire     = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed self-checking bench for mc_ctrl.
// Output vector: {pcen,irw,rw,mw,iord,rdst,m2r,asa}_srcb_pcsrc_alu_ret_ill.
module tb_mc_ctrl;
  import mc_pkg::*;

  logic       clk, rst, zero, mem_rdy;
  logic [5:0] op, funct;
  logic       pcen, irwrite, regwrite, memwrite;
  logic       iord, regdst, memtoreg, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       retire, illegal;
  logic [16:0] obs;
  int n_cmp = 0;
  int n_err = 0;

  localparam logic [16:0] V_ZERO  = 17'b00000000_00_00_000_0_0;
  localparam logic [16:0] V_FET1  = 17'b11000000_01_00_010_0_0;
  localparam logic [16:0] V_FET0  = 17'b00000000_01_00_010_0_0;
  localparam logic [16:0] V_DEC   = 17'b00000000_11_00_010_0_0;
  localparam logic [16:0] V_ADR   = 17'b00000001_10_00_010_0_0;
  localparam logic [16:0] V_RD    = 17'b00001000_00_00_000_0_0;
  localparam logic [16:0] V_MWB   = 17'b00100010_00_00_000_1_0;
  localparam logic [16:0] V_WR0   = 17'b00001000_00_00_000_0_0;
  localparam logic [16:0] V_WR1   = 17'b00011000_00_00_000_1_0;
  localparam logic [16:0] V_XSLT  = 17'b00000001_00_00_111_0_0;
  localparam logic [16:0] V_XSUB  = 17'b00000001_00_00_110_0_0;
  localparam logic [16:0] V_AWB   = 17'b00100100_00_00_000_1_0;
  localparam logic [16:0] V_BR1   = 17'b10000001_00_01_110_1_0;
  localparam logic [16:0] V_BR0   = 17'b00000001_00_01_110_1_0;
  localparam logic [16:0] V_JMP   = 17'b10000000_00_10_000_1_0;
  localparam logic [16:0] V_AIWB  = 17'b00100000_00_00_000_1_0;
  localparam logic [16:0] V_TRAP  = 17'b00000000_00_00_000_0_1;

  assign obs = {pcen, irwrite, regwrite, memwrite, iord, regdst,
                memtoreg, alusrca, alusrcb, pcsrc, alucontrol,
                retire, illegal};

  mc_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_rdy    (mem_rdy),
    .pcen       (pcen),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .iord       (iord),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .alucontrol (alucontrol),
    .retire     (retire),
    .illegal    (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [16:0] o,
                     input logic [16:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, o, e);
    end
  endtask

  task automatic chk(input string tag, input logic [16:0] e);
    #1;
    cmp(tag, obs, e);
  endtask

  task automatic stchk(input string tag, input state_t e);
    cmp(tag, 17'(dut.state_q), 17'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; mem_rdy = 1'b1; zero = 1'b0;
    op = OP_LW; funct = 6'b0;
    #3;
    chk("rst_hold", V_ZERO);
    stchk("rst_state", S_FETCH);
    tick();
    chk("rst_clk", V_ZERO);
    mem_rdy = 1'b0; rst = 1'b1;
    chk("fetch_wait", V_FET0);
    tick();
    stchk("fetch_stay", S_FETCH);
    mem_rdy = 1'b1;
    // lw: 5 cycles
    chk("lw_fetch", V_FET1);
    tick(); chk("lw_dec", V_DEC);
    tick(); chk("lw_adr", V_ADR);
    tick(); chk("lw_rd", V_RD);
    tick(); chk("lw_wb", V_MWB);
    tick(); stchk("lw_next", S_FETCH);
    // sw with 3 wait cycles
    op = OP_SW;
    chk("sw_fetch", V_FET1);
    tick(); chk("sw_dec", V_DEC);
    tick(); chk("sw_adr", V_ADR);
    tick(); mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_wait", V_WR0);
      tick();
    end
    mem_rdy = 1'b1;
    chk("sw_wr", V_WR1);
    tick(); stchk("sw_next", S_FETCH);
    // beq taken
    op = OP_BEQ; zero = 1'b1;
    chk("beq1_fetch", V_FET1);
    tick(); chk("beq1_dec", V_DEC);
    tick(); chk("beq1_br", V_BR1);
    tick(); stchk("beq1_next", S_FETCH);
    // beq not taken
    zero = 1'b0;
    chk("beq0_fetch", V_FET1);
    tick(); chk("beq0_dec", V_DEC);
    tick(); chk("beq0_br", V_BR0);
    tick(); stchk("beq0_next", S_FETCH);
    // addi
    op = OP_ADDI;
    chk("addi_fetch", V_FET1);
    tick(); chk("addi_dec", V_DEC);
    tick(); chk("addi_ex", V_ADR);
    tick(); chk("addi_wb", V_AIWB);
    tick(); stchk("addi_next", S_FETCH);
    // j
    op = OP_J;
    chk("j_fetch", V_FET1);
    tick(); chk("j_dec", V_DEC);
    tick(); chk("j_jmp", V_JMP);
    tick(); stchk("j_next", S_FETCH);
    // R-type slt
    op = OP_RTYPE; funct = 6'b101010;
    chk("slt_fetch", V_FET1);
    tick(); chk("slt_dec", V_DEC);
    tick(); chk("slt_exec", V_XSLT);
    tick(); chk("slt_wb", V_AWB);
    tick(); stchk("slt_next", S_FETCH);
    // R-type sub
    funct = 6'b100010;
    chk("sub_fetch", V_FET1);
    tick(); chk("sub_dec", V_DEC);
    tick(); chk("sub_exec", V_XSUB);
    tick(); chk("sub_wb", V_AWB);
    tick(); stchk("sub_next", S_FETCH);
    // R-type bad funct -> TRAP
    funct = 6'b000000;
    chk("badfn_fetch", V_FET1);
    tick(); chk("badfn_dec", V_DEC);
    tick(); #1;
    cmp("badfn_exec_rw", 17'(regwrite), 17'd0);
    tick(); stchk("badfn_trap", S_TRAP);
    for (int i = 0; i < 10; i++) begin
      chk("trap_hold", V_TRAP);
      tick();
    end
    // async reset out of TRAP
    #1; rst = 1'b0;
    chk("trap_rst", V_ZERO);
    stchk("trap_rst_st", S_FETCH);
    rst = 1'b1;
    // illegal opcode
    op = 6'b111111;
    chk("ill_fetch", V_FET1);
    tick(); chk("ill_dec", V_DEC);
    tick(); chk("ill_trap", V_TRAP);
    tick(); chk("ill_hold", V_TRAP);
    rst = 1'b0; #1; rst = 1'b1;
    // lw interrupted by reset in MEMRD
    op = OP_LW;
    chk("lw2_fetch", V_FET1);
    tick(); chk("lw2_dec", V_DEC);
    tick(); chk("lw2_adr", V_ADR);
    tick(); chk("lw2_rd", V_RD);
    #1; rst = 1'b0;
    chk("lw2_rst", V_ZERO);
    stchk("lw2_rst_st", S_FETCH);
    tick(); chk("lw2_rst_clk", V_ZERO);
    stchk("lw2_rst_clk_st", S_FETCH);
    rst = 1'b1;
    chk("lw2_refetch", V_FET1);
    tick(); chk("lw2_redec", V_DEC);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (sole clock); rst input 1 (reset, asynchronous, active-low).
REQ-002 SHALL have op input 6 (instr[31:26]) and funct input 6 (instr[5:0]), both from the instruction register.
REQ-003 SHALL have zero input 1 (ALU result == 0) and mem_rdy input 1 (memory access completes this cycle).
REQ-004 SHALL have pcen output 1 and irwrite output 1 (PC / instruction-register write enables).
REQ-005 SHALL have regwrite output 1 and memwrite output 1 (register-file / data-memory write enables).
REQ-006 SHALL have iord, regdst, memtoreg and alusrca outputs, each 1 bit, as mux selects (1 = data address, rd, readdata, register A).
REQ-007 SHALL have alusrcb output 2 (00 B, 01 const 1, 10 signImm, 11 signImm<<2) and pcsrc output 2 (00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have alucontrol output 3 (010 add, 110 sub, 000 and, 001 or, 111 slt).
REQ-009 SHALL have retire output 1 (one-cycle pulse per completed instruction) and illegal output 1 (sticky trap flag).

Function
REQ-010 SHALL hold one registered state from: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP.
REQ-011 SHALL in FETCH drive iord=0, alusrca=0, alusrcb=01, pcsrc=00 and alucontrol=add.
REQ-012 SHALL in FETCH assert irwrite and pcen only when mem_rdy=1, move to DECODE on mem_rdy=1, and otherwise stay in FETCH.
REQ-013 SHALL in DECODE drive alusrca=0, alusrcb=11, alucontrol=add, then branch on op.
REQ-014 DECODE targets: lw 100011 and sw 101011 go to MEMADR; R-type 000000 to EXEC; beq 000100 to BRANCH; addi 001000 to ADDIEX; j 000010 to JUMP; any other op to TRAP.
REQ-015 SHALL in MEMADR and ADDIEX drive alusrca=1, alusrcb=10, alucontrol=add.
REQ-016 MEMADR SHALL go to MEMRD for lw and to MEMWR for sw.
REQ-017 SHALL in MEMRD drive iord=1 and hold until mem_rdy=1, then go to MEMWB.
REQ-018 SHALL in MEMWR drive iord=1, assert memwrite only with mem_rdy=1, hold until mem_rdy=1, then go to FETCH with retire=1.
REQ-019 SHALL in MEMWB drive regwrite=1, regdst=0, memtoreg=1, retire=1, then go to FETCH.
REQ-020 SHALL in EXEC drive alusrca=1, alusrcb=00 and alucontrol decoded from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
REQ-021 An unlisted funct in EXEC SHALL go to TRAP without any write; a listed funct SHALL go to ALUWB.
REQ-022 SHALL in ALUWB drive regwrite=1, regdst=1, memtoreg=0, retire=1, then go to FETCH.
REQ-023 SHALL in ADDIWB drive regwrite=1, regdst=0, memtoreg=0, retire=1, then go to FETCH.
REQ-024 SHALL in BRANCH drive alusrca=1, alusrcb=00, alucontrol=sub, pcsrc=01, pcen=zero, retire=1, then go to FETCH.
REQ-025 SHALL in JUMP drive pcsrc=10, pcen=1, retire=1, then go to FETCH.
REQ-026 SHALL in TRAP set illegal=1, keep all enables 0, and remain in TRAP until reset.
REQ-027 Outputs SHALL be combinational from state, with mem_rdy/zero/funct only where stated above; unlisted outputs in any state SHALL be 0.
REQ-028 Instruction latency with mem_rdy tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.

Reset
REQ-029 While rst=0 the state SHALL be forced asynchronously to FETCH and illegal cleared to 0.
REQ-030 While rst=0 pcen, irwrite, regwrite, memwrite and retire SHALL be 0 regardless of mem_rdy, and all selects SHALL be 0.
REQ-031 Reset asserted mid-instruction SHALL abandon it with no further write; the first FETCH follows the rst rising edge.

Structure
REQ-032 Shared package mc_pkg SHALL hold the state enum, opcode/funct constants and alucontrol encodings.
REQ-033 Funct-to-alucontrol decode SHALL be the sub-module alu_dec.

Verification
REQ-034 Reset then lw with mem_rdy=1: states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite and memtoreg=1 in cycle 5 only; retire once.
REQ-035 sw with mem_rdy low 3 cycles in MEMWR: memwrite=0 for 3 cycles, then 1 for exactly 1 cycle; retire on that cycle.
REQ-036 beq with zero=1: pcen=1, pcsrc=01 in cycle 3; repeat with zero=0: pcen=0; next FETCH both times.
REQ-037 R-type funct 101010: alucontrol=111 in EXEC; funct 000000: TRAP, illegal=1 held 10 cycles, regwrite never 1.
REQ-038 op 111111 goes to TRAP; rst pulsed low mid-MEMRD gives FETCH, illegal=0 and all enables 0 immediately, without waiting for clk.
